// File: rtl/lock_pkg.sv
// Shared definitions for the lock keypad and its code sender:
// operation modes, sender state codes and the lock's display symbols.
package lock_pkg;

    typedef enum logic [1:0] {
        MODE_UNLOCK   = 2'b00,
        MODE_CHANGE   = 2'b01,
        MODE_BACKDOOR = 2'b10,
        MODE_RSVD     = 2'b11
    } mode_t;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CLR   = 4'd1,
        S_WAKE  = 4'd2,
        S_CHG   = 4'd3,
        S_SETUP = 4'd4,
        S_ENT   = 4'd5,
        S_GAP   = 4'd6,
        S_DONE  = 4'd7,
        S_ABORT = 4'd8
    } sender_state_t;

    // 5-bit symbols shown on the lock's display
    localparam logic [4:0] SYM_BLANK = 5'h1F;
    localparam logic [4:0] SYM_DASH  = 5'h10;
    localparam logic [4:0] SYM_L     = 5'h11;
    localparam logic [4:0] SYM_O     = 5'h12;
    localparam logic [4:0] SYM_P     = 5'h13;
    localparam logic [4:0] SYM_E     = 5'h14;
    localparam logic [4:0] SYM_BD    = 5'h15;

    // Digit i of a 4-digit code, digit 0 being the most significant nibble
    function automatic logic [3:0] code_nibble(input logic [15:0] c, input logic [2:0] i);
        logic [3:0] n;
        case (i[1:0])
            2'd0:    n = c[15:12];
            2'd1:    n = c[11:8];
            2'd2:    n = c[7:4];
            default: n = c[3:0];
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lock_code_sender_if.sv
// Request and keypad-side signals between a controller and the code sender.
interface lock_code_sender_if;
    import lock_pkg::*;

    logic        start;
    logic [1:0]  mode;
    logic [15:0] code;
    logic        abort;
    logic [3:0]  sw_out;
    logic        ent_out;
    logic        clr_out;
    logic        change_out;
    logic        busy;
    logic        done;
    logic [2:0]  digit_idx;

    modport master (
        output start, mode, code, abort,
        input  sw_out, ent_out, clr_out, change_out, busy, done, digit_idx
    );

    modport slave (
        input  start, mode, code, abort,
        output sw_out, ent_out, clr_out, change_out, busy, done, digit_idx
    );
endinterface

// File: rtl/lock_code_sender.sv
// Plays a stored 16-bit code into the lock FSM one keypad field per tick,
// mimicking a user: clear, wake/change, then each digit set up and entered.
// The tick after a start is accepted is an arming tick: busy is up, strobes low.
module lock_code_sender
    import lock_pkg::*;
#(
    parameter int SETUP_TICKS = 1,
    parameter int GAP_TICKS   = 1,
    parameter int BD_PULSES   = 6
) (
    input  logic               divided_clk,
    input  logic               rst,
    lock_code_sender_if.slave  bus
);

    // Keep every pause below the lock's 15-tick auto-lock timeout
    if (SETUP_TICKS < 1 || SETUP_TICKS > 6) begin : g_bad_setup
        $error("SETUP_TICKS must be in 1..6");
    end
    if (GAP_TICKS < 1 || GAP_TICKS > 6) begin : g_bad_gap
        $error("GAP_TICKS must be in 1..6");
    end
    if (BD_PULSES < 1 || BD_PULSES > 7) begin : g_bad_bd
        $error("BD_PULSES must be in 1..7");
    end
    if (SETUP_TICKS + GAP_TICKS + 1 > 14) begin : g_bad_window
        $error("SETUP_TICKS+GAP_TICKS+1 must not exceed 14");
    end

    localparam logic [3:0] SETUP_LOAD   = 4'(SETUP_TICKS - 1);
    localparam logic [3:0] GAP_LOAD     = 4'(GAP_TICKS - 1);
    // The lock spends one extra tick passing through CHANGING
    localparam logic [3:0] CHG_GAP_LOAD = 4'(GAP_TICKS);
    localparam logic [2:0] BD_TOTAL     = 3'(BD_PULSES);

    sender_state_t state_reg, state_next;
    logic [3:0]    tick_reg, tick_next;
    logic [15:0]   code_reg;
    mode_t         mode_reg;
    logic [2:0]    field_reg;
    logic [2:0]    field_total;
    logic          accept;

    logic [3:0]    sw_reg;
    logic          ent_reg, clr_reg, change_reg, busy_reg, done_reg;
    logic [2:0]    idx_reg;

    assign bus.sw_out     = sw_reg;
    assign bus.ent_out    = ent_reg;
    assign bus.clr_out    = clr_reg;
    assign bus.change_out = change_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.digit_idx  = idx_reg;

    assign accept      = (state_reg == S_IDLE) && !busy_reg && bus.start
                         && (bus.mode != MODE_RSVD);
    assign field_total = (mode_reg == MODE_BACKDOOR) ? BD_TOTAL : 3'd4;

    // Next state and tick-counter reload; abort overrides any busy transition
    always_comb begin
        state_next = state_reg;
        tick_next  = (tick_reg == 4'd0) ? 4'd0 : tick_reg - 4'd1;
        case (state_reg)
            S_IDLE:  if (busy_reg)
                         state_next = (mode_reg == MODE_BACKDOOR) ? S_SETUP : S_CLR;
            S_CLR:   state_next = (mode_reg == MODE_CHANGE) ? S_CHG : S_WAKE;
            S_WAKE,
            S_CHG,
            S_ENT:   state_next = S_GAP;
            S_SETUP: if (tick_reg == 4'd0) state_next = S_ENT;
            S_GAP:   if (tick_reg == 4'd0)
                         state_next = (field_reg == field_total) ? S_DONE : S_SETUP;
            S_DONE,
            S_ABORT: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (bus.abort && busy_reg && state_reg != S_ABORT) begin
            state_next = S_ABORT;
        end
        if (state_next != state_reg) begin
            case (state_next)
                S_SETUP: tick_next = SETUP_LOAD;
                S_GAP:   tick_next = (state_reg == S_CHG) ? CHG_GAP_LOAD : GAP_LOAD;
                default: tick_next = 4'd0;
            endcase
        end
    end

    // Sender FSM; every output is registered from the state being entered
    always_ff @(posedge divided_clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            tick_reg   <= 4'd0;
            code_reg   <= 16'd0;
            mode_reg   <= MODE_UNLOCK;
            field_reg  <= 3'd0;
            sw_reg     <= 4'd0;
            ent_reg    <= 1'b0;
            clr_reg    <= 1'b0;
            change_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            idx_reg    <= 3'd0;
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            if (accept) begin
                code_reg <= bus.code;
                mode_reg <= mode_t'(bus.mode);
            end
            // Field counter advances as each digit/backdoor pulse is entered
            if (state_reg == S_IDLE) begin
                field_reg <= 3'd0;
            end else if (state_reg == S_ENT) begin
                field_reg <= field_reg + 3'd1;
            end

            ent_reg    <= (state_next == S_ENT) || (state_next == S_WAKE);
            // An abort right after the clear tick skips a second back-to-back clr
            clr_reg    <= (state_next == S_CLR) || (state_next == S_ABORT && !clr_reg);
            change_reg <= (state_next == S_CHG);
            done_reg   <= (state_next == S_DONE);
            busy_reg   <= (state_next == S_IDLE) ? accept : (state_next != S_DONE);
            idx_reg    <= (state_next == S_IDLE) ? 3'd0 : idx_reg + {2'b00, ent_reg};

            // The nibble is held through the enter pulse and the following gap
            case (state_next)
                S_SETUP: sw_reg <= (mode_reg == MODE_BACKDOOR) ? 4'hF
                                   : code_nibble(code_reg, field_reg);
                S_ENT,
                S_GAP:   sw_reg <= sw_reg;
                S_IDLE:  sw_reg <= (accept && bus.mode == MODE_BACKDOOR) ? 4'hF : 4'h0;
                default: sw_reg <= 4'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_lock_code_sender.sv
// Bench for lock_code_sender: spec table vectors, random runs against a
// sequence-level reference model, and hand-written abort/guard/reset cases.
module tb_lock_code_sender;
    import lock_pkg::*;

    localparam int SETUP = 1;
    localparam int GAP   = 1;
    localparam int BD    = 6;

    logic divided_clk = 1'b0;
    logic rst = 1'b1;
    always #5 divided_clk = ~divided_clk;

    lock_code_sender_if bus ();

    lock_code_sender #(.SETUP_TICKS(SETUP), .GAP_TICKS(GAP), .BD_PULSES(BD)) dut (
        .divided_clk(divided_clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [3:0] sw;
        logic       ent;
        logic       clr;
        logic       chg;
        logic       busy;
        logic       done;
        logic [2:0] idx;
    } obs_t;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] code;
        int          done_edge;
        logic [31:0] ent_m;
        logic [31:0] clr_m;
        logic [31:0] chg_m;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    obs_t exp_q[$];
    obs_t got[0:63];
    int   n_got;
    int   model_cnt;

    function automatic obs_t sample();
        obs_t s;
        s.sw   = bus.sw_out;
        s.ent  = bus.ent_out;
        s.clr  = bus.clr_out;
        s.chg  = bus.change_out;
        s.busy = bus.busy;
        s.done = bus.done;
        s.idx  = bus.digit_idx;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference model: what a user would key in, one record per tick
    task automatic m_add(input logic [3:0] sw, input logic ent, input logic clr, input logic chg);
        obs_t r;
        r = '0;
        r.sw = sw; r.ent = ent; r.clr = clr; r.chg = chg;
        r.busy = 1'b1;
        r.idx = model_cnt[2:0];
        exp_q.push_back(r);
        if (ent) model_cnt++;
    endtask

    task automatic m_field(input logic [3:0] nib);
        repeat (SETUP) m_add(nib, 1'b0, 1'b0, 1'b0);
        m_add(nib, 1'b1, 1'b0, 1'b0);
        repeat (GAP) m_add(nib, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_run(input logic [1:0] m, input logic [15:0] c);
        obs_t r;
        exp_q.delete();
        model_cnt = 0;
        m_add((m == MODE_BACKDOOR) ? 4'hF : 4'h0, 1'b0, 1'b0, 1'b0);
        if (m == MODE_BACKDOOR) begin
            for (int p = 0; p < BD; p++) m_field(4'hF);
        end else begin
            m_add(4'h0, 1'b0, 1'b1, 1'b0);
            if (m == MODE_UNLOCK) begin
                m_add(4'h0, 1'b1, 1'b0, 1'b0);
                repeat (GAP) m_add(4'h0, 1'b0, 1'b0, 1'b0);
            end else begin
                m_add(4'h0, 1'b0, 1'b0, 1'b1);
                repeat (GAP + 1) m_add(4'h0, 1'b0, 1'b0, 1'b0);
            end
            for (int d = 0; d < 4; d++) m_field(c[15 - 4*d -: 4]);
        end
        r = '0; r.done = 1'b1; r.idx = model_cnt[2:0];
        exp_q.push_back(r);
        r = '0;
        exp_q.push_back(r);
    endtask

    // Start a run, capture edge 0 through the idle tick after done; optionally
    // pulse start again so that it is sampled at edge 'poke'
    task automatic do_run(input string name, input logic [1:0] m, input logic [15:0] c, input int poke);
        int n;
        int done_at;
        model_run(m, c);
        bus.mode = m; bus.code = c; bus.start = 1'b1;
        @(posedge divided_clk); #1;
        bus.start = 1'b0; bus.mode = 2'b11; bus.code = 16'($urandom);
        got[0] = sample();
        n = 1;
        done_at = -1;
        while (n < 50) begin
            if (n == poke) begin
                bus.mode = MODE_UNLOCK; bus.start = 1'b1;
            end
            @(posedge divided_clk); #1;
            bus.start = 1'b0; bus.mode = 2'b11;
            got[n] = sample();
            n++;
            if (done_at >= 0) break;
            if (got[n-1].done) done_at = n - 1;
        end
        n_got = n;
        $display("run %s mode=%0d code=%h edges=%0d done_at=%0d", name, m, c, n, done_at);
        check($sformatf("%s length", name), 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            check($sformatf("%s edge%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
        end
    endtask

    vec_t vecs[3];

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] em, cm, hm;
        int de;
        int dones;
        logic saw_done;

        vecs[0] = '{MODE_UNLOCK,   16'h3456, 16, 32'h0000_4924, 32'h2, 32'h0};
        vecs[1] = '{MODE_CHANGE,   16'h1234, 17, 32'h0000_9240, 32'h2, 32'h4};
        vecs[2] = '{MODE_BACKDOOR, 16'hA5C3, 19, 32'h0002_4924, 32'h0, 32'h0};

        bus.start = 1'b0; bus.mode = 2'b00; bus.code = 16'h0; bus.abort = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge divided_clk);
        #1;
        check("reset outputs", 32'(sample()), 32'h0);
        rst = 1'b0;
        @(posedge divided_clk); #1;
        check("idle after reset", 32'(sample()), 32'h0);

        // Spec vectors: strobe timing and done edge
        for (int v = 0; v < 3; v++) begin
            do_run($sformatf("vec%0d", v), vecs[v].mode, vecs[v].code, -1);
            em = '0; cm = '0; hm = '0; de = -1;
            for (int i = 0; i < n_got && i < 32; i++) begin
                em[i] = got[i].ent;
                cm[i] = got[i].clr;
                hm[i] = got[i].chg;
                if (got[i].done && de < 0) de = i;
            end
            check($sformatf("vec%0d ent edges", v), em, vecs[v].ent_m);
            check($sformatf("vec%0d clr edges", v), cm, vecs[v].clr_m);
            check($sformatf("vec%0d change edges", v), hm, vecs[v].chg_m);
            check($sformatf("vec%0d done edge", v), 32'(de), 32'(vecs[v].done_edge));
            if (de > 0 && de < 64)
                check($sformatf("vec%0d busy at done", v), 32'(got[de].busy), 32'h0);
        end

        // Random runs against the model
        for (int r = 0; r < 8; r++) begin
            do_run($sformatf("rand%0d", r), 2'($urandom_range(0, 2)), 16'($urandom), -1);
        end

        // Start while busy is ignored
        do_run("busy_guard", MODE_UNLOCK, 16'h3456, 5);
        check("guard idx e6", 32'(got[6].idx), 32'd2);
        check("guard idx e9", 32'(got[9].idx), 32'd3);

        // Abort at edge 7 of an UNLOCK run
        bus.mode = MODE_UNLOCK; bus.code = 16'h3456; bus.start = 1'b1;
        @(posedge divided_clk); #1;
        bus.start = 1'b0; bus.mode = 2'b11;
        saw_done = 1'b0;
        repeat (7) begin
            @(posedge divided_clk); #1;
            saw_done |= bus.done;
        end
        bus.abort = 1'b1;
        @(posedge divided_clk); #1;
        bus.abort = 1'b0;
        $display("abort edge8 sw=%h ent=%b clr=%b busy=%b", bus.sw_out, bus.ent_out, bus.clr_out, bus.busy);
        check("abort e8 clr", 32'(bus.clr_out), 32'd1);
        check("abort e8 ent", 32'(bus.ent_out), 32'd0);
        check("abort e8 sw", 32'(bus.sw_out), 32'd0);
        check("abort e8 busy", 32'(bus.busy), 32'd1);
        @(posedge divided_clk); #1;
        saw_done |= bus.done;
        check("abort e9 outputs", 32'(sample()), 32'h0);
        check("abort no done", 32'(saw_done), 32'd0);
        do_run("after_abort", MODE_UNLOCK, 16'h1234, -1);

        // Reserved mode never starts
        bus.mode = 2'b11; bus.code = 16'hFFFF; bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge divided_clk); #1;
            bus.start = 1'b0;
            check($sformatf("reserved edge%0d", i), 32'(sample()), 32'h0);
        end

        // start and abort together in idle: start wins, run completes
        bus.mode = MODE_CHANGE; bus.code = 16'($urandom); bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge divided_clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        check("start+abort busy", 32'(bus.busy), 32'd1);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge divided_clk); #1;
            if (bus.done) dones++;
        end
        $display("start+abort run done pulses=%0d", dones);
        check("start+abort done count", 32'(dones), 32'd1);

        // Asynchronous reset mid-sequence at edge 10.5
        bus.mode = MODE_UNLOCK; bus.code = 16'h3456; bus.start = 1'b1;
        @(posedge divided_clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge divided_clk);
        #1;
        check("pre-rst busy", 32'(bus.busy), 32'd1);
        #4;
        rst = 1'b1;
        #1;
        $display("rst mid-run outputs=%h", sample());
        check("rst async outputs", 32'(sample()), 32'h0);
        #1;
        rst = 1'b0;
        @(posedge divided_clk); #1;
        check("post-rst idle", 32'(sample()), 32'h0);
        do_run("after_rst", MODE_BACKDOOR, 16'h0000, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
